// File: rtl/race_pkg.sv
// Shared defaults and types for the race-logic wave encoder.
// The optional null-value encoding is enabled with the RACE_ENC_NULL_EN macro.
package race_pkg;

    localparam int RACE_N   = 16;
    localparam int RACE_W   = 6;
    localparam int RACE_GAP = 4;

    // Count carries W value bits plus a terminal flag bit.
    localparam int RACE_CNT_W = RACE_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } race_state_t;

endpackage

// File: rtl/race_line_cell.sv
// One temporal-coded output line: a sticky-low register that falls once val <= count
// during RUN and returns high whenever the wave is not running.
module race_line_cell #(
    parameter int W     = 6,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     val,
    input  logic [CNT_W-1:0] count,
    input  logic             run,
    input  logic             null_val,
    output logic             wave
);

    logic low_q;

    // val and count describe the cycle about to start, so the registered line
    // is already correct in the first cycle of the wave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_q <= 1'b0;
        end else begin
            low_q <= run && !null_val && (low_q || (CNT_W'(val) <= count));
        end
    end

    assign wave = ~low_q;

endmodule

// File: rtl/race_wave_encoder.sv
// Converts N binary values into one temporal wave (IDLE -> RUN -> RECOVER -> IDLE).
// Define RACE_ENC_NULL_EN to treat the all-ones value as null (line never falls).
module race_wave_encoder
    import race_pkg::*;
#(
    parameter int N   = RACE_N,
    parameter int W   = RACE_W,
    parameter int GAP = RACE_GAP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N*W-1:0] in_values,
    output logic [N-1:0] wave_out,
    output logic         wave_busy,
    output logic         wave_done
);

    localparam int CNT_W = W + 1;
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'((1 << W) - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

    race_state_t      state;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     val_q   [N];
    logic [W-1:0]     val_nxt [N];
    logic [CNT_W-1:0] count_nxt;
    logic             accept;
    logic             run_nxt;

    // Handshake: a wave is accepted on any rising edge where in_valid and in_ready are
    // both high; in_ready is high only in IDLE, and in_valid at other times is ignored.
    always_comb begin
        accept    = (state == IDLE) && in_valid;
        run_nxt   = accept || ((state == RUN) && (count != RUN_LAST));
        count_nxt = accept ? '0 : count + 1'b1;
        for (int i = 0; i < N; i++) begin
            val_nxt[i] = accept ? in_values[i*W +: W] : val_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b1;
            wave_busy <= 1'b0;
            wave_done <= 1'b0;
            for (int i = 0; i < N; i++) val_q[i] <= '0;
        end else begin
            wave_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) val_q[i] <= val_nxt[i];
                        count     <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        wave_busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (count == RUN_LAST) begin
                        count     <= '0;
                        state     <= RECOVER;
                        wave_done <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RECOVER: begin
                    if (count == GAP_LAST) begin
                        count     <= '0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        wave_busy <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_line
        logic null_val;
`ifdef RACE_ENC_NULL_EN
        assign null_val = (val_nxt[i] == {W{1'b1}});
`else
        assign null_val = 1'b0;
`endif
        race_line_cell #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .val      (val_nxt[i]),
            .count    (count_nxt),
            .run      (run_nxt),
            .null_val (null_val),
            .wave     (wave_out[i])
        );
    end

endmodule

// File: tb/tb_race_wave_encoder.sv
// Directed + randomized bench for race_wave_encoder; expected waves come from each line's
// value directly (line high while cycle < value), with RACE_ENC_NULL_EN selecting null handling.
module tb_race_wave_encoder;
    import race_pkg::*;

    localparam int N       = RACE_N;
    localparam int W       = RACE_W;
    localparam int GAP     = RACE_GAP;
    localparam int RUN_LEN = 1 << W;
    localparam int PERIOD  = RUN_LEN + GAP + 1;
`ifdef RACE_ENC_NULL_EN
    localparam bit NULL_EN = 1'b1;
`else
    localparam bit NULL_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_values;
    logic [N-1:0]   wave_out;
    logic           wave_busy;
    logic           wave_done;

    int checks;
    int errors;
    int cyc;
    int done_pulses;
    int waves_completed;
    int accept_cyc[$];
    logic [W-1:0] cur_vals [N];
    logic [W:0]   exp_q[$];

    race_wave_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_values (in_values),
        .wave_out  (wave_out),
        .wave_busy (wave_busy),
        .wave_done (wave_done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) accept_cyc.push_back(cyc);
        if (rst_n && wave_done) done_pulses <= done_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_vals();
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = cur_vals[i];
        return p;
    endfunction

    function automatic bit is_null(input logic [W-1:0] v);
        return NULL_EN && (int'(v) == RUN_LEN - 1);
    endfunction

    // Reference: in RUN cycle j a line is high while j < value (or forever if null).
    function automatic logic [N-1:0] model_wave(input int j);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = is_null(cur_vals[i]) || (j < int'(cur_vals[i]));
        return m;
    endfunction

    // driver: offer cur_vals, follow the wave cycle by cycle; abort_at >= 0 resets mid-RUN.
    task automatic run_wave(input bit keep_valid, input int abort_at);
        int waited;
        int fall [N];
        in_values = pack_vals();
        in_valid  = 1'b1;
        waited    = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("accept_timeout", 32'(waited < 200), 32'd1);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(is_null(cur_vals[i]) ? (W+1)'(RUN_LEN) : {1'b0, cur_vals[i]});
            fall[i] = RUN_LEN;
        end
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
        for (int j = 0; j < RUN_LEN; j++) begin
            if (j == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_wave", 32'(wave_out), 32'(N'('1)));
                chk("abort_ready", 32'(in_ready), 32'd1);
                chk("abort_busy", 32'(wave_busy), 32'd0);
                @(posedge clk); #2;
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk("abort_idle_ready", 32'(in_ready), 32'd1);
                chk("abort_idle_wave", 32'(wave_out), 32'(N'('1)));
                return;
            end
            chk($sformatf("run_wave_j%0d", j), 32'(wave_out), 32'(model_wave(j)));
            if (j == 0 || j == RUN_LEN - 1) begin
                chk("run_ready", 32'(in_ready), 32'd0);
                chk("run_busy", 32'(wave_busy), 32'd1);
                chk("run_done", 32'(wave_done), 32'd0);
            end
            for (int i = 0; i < N; i++)
                if (wave_out[i] === 1'b0 && fall[i] == RUN_LEN) fall[i] = j;
            in_values = N*W'({$urandom, $urandom, $urandom});
            @(posedge clk); #1;
        end
        for (int i = 0; i < N; i++) begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk($sformatf("fall_line%0d", i), 32'(fall[i]), 32'(e));
        end
        for (int g = 0; g < GAP; g++) begin
            chk("recover_wave", 32'(wave_out), 32'(N'('1)));
            chk("recover_done", 32'(wave_done), 32'(g == 0));
            chk("recover_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(wave_busy), 32'd0);
        chk("idle_wave", 32'(wave_out), 32'(N'('1)));
        waves_completed++;
    endtask

    task automatic random_vals();
        for (int i = 0; i < N; i++) cur_vals[i] = W'($urandom_range(0, RUN_LEN - 1));
    endtask

    initial begin
        int sorter_v [N];
        checks = 0; errors = 0; cyc = 0; done_pulses = 0; waves_completed = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_values = '0;
        #12;
        chk("reset_wave", 32'(wave_out), 32'(N'('1)));
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(wave_busy), 32'd0);
        chk("reset_done", 32'(wave_done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // sorter order vector
        sorter_v = '{41, 5, 30, 20, 15, 10, 43, 17, 35, 44, 26, 37, 11, 7, 40, 21};
        for (int i = 0; i < N; i++) cur_vals[i] = W'(sorter_v[i]);
        run_wave(1'b0, -1);

        // all zero, then ties on lines 2..4
        for (int i = 0; i < N; i++) cur_vals[i] = '0;
        run_wave(1'b0, -1);
        random_vals();
        cur_vals[2] = 9; cur_vals[3] = 9; cur_vals[4] = 9;
        run_wave(1'b0, -1);

        // maximum value on line 6
        random_vals();
        cur_vals[6] = W'(RUN_LEN - 1);
        run_wave(1'b0, -1);

        // back-to-back with in_valid held high
        random_vals();
        run_wave(1'b1, -1);
        random_vals();
        run_wave(1'b1, -1);
        in_valid = 1'b0;
        chk("b2b_accept_gap",
            32'(accept_cyc[accept_cyc.size()-1] - accept_cyc[accept_cyc.size()-2]), 32'(PERIOD));

        // reset in RUN cycle 20, then a fresh wave
        random_vals();
        run_wave(1'b0, 20);
        random_vals();
        run_wave(1'b0, -1);

        for (int k = 0; k < 4; k++) begin
            random_vals();
            run_wave(1'b0, -1);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("done_pulse_count", 32'(done_pulses), 32'(waves_completed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
